// File: rtl/mem_sram_stage_pkg.sv
// Shared definitions for the SRAM memory stage: FSM encoding, default parameters
// and the byte-address to word-index translation.
package mem_sram_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } sram_state_e;

  localparam int unsigned DEFAULT_BASE_ADDR   = 32'd1024;
  localparam int unsigned DEFAULT_ADDR_W      = 32'd18;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 32'd2;

  function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                             input logic [31:0] base);
    return (byte_addr - base) >> 2;
  endfunction

endpackage

// File: rtl/mem_sram_stage_wait_counter.sv
// Wait-state counter for one SRAM halfword phase: counts 0..WAIT_CYCLES-1 and wraps,
// so the same counter serves the low and the high halfword back to back.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 32'd2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last,
  output logic penult
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_VAL   = CNT_W'(WAIT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] PENULT_VAL = CNT_W'(WAIT_CYCLES - 32'd2);

  logic [CNT_W-1:0] cnt_r;

  // Count register: synchronous clear outside the access phases, wrap at the last cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      if (last) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last   = (cnt_r == LAST_VAL);
  assign penult = (cnt_r == PENULT_VAL);

endmodule

// File: rtl/mem_sram_stage.sv
// Memory stage: splits each 32-bit load/store into two 16-bit SRAM accesses
// (low half first) with wait states, stalling the pipeline via ready.
module mem_sram_stage
  import mem_sram_stage_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [31:0]       alu_res,
  input  logic [31:0]       val_rm,
  input  logic [3:0]        dest,
  output logic              wb_en_out,
  output logic              mem_r_out,
  output logic [3:0]        dest_out,
  output logic [31:0]       alu_res_out,
  output logic [31:0]       mem_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_we_n
);

  sram_state_e       state_r;
  sram_state_e       state_nxt_s;
  logic              req_s;
  logic              is_write_s;
  logic              is_read_s;
  logic              in_phase_s;
  logic              cnt_last_s;
  logic              cnt_penult_s;
  logic              we_low_nxt_s;
  logic              oe_nxt_s;
  logic              load_lo_s;
  logic              load_hi_s;
  logic              capture_lo_s;
  logic              capture_hi_s;
  logic [ADDR_W-1:0] addr_lo_s;
  logic [ADDR_W-1:0] addr_hi_s;

  assign wb_en_out   = wb_en;
  assign mem_r_out   = mem_r;
  assign dest_out    = dest;
  assign alu_res_out = alu_res;

  // A simultaneous read and write request is serviced as a write.
  assign req_s      = mem_r | mem_w;
  assign is_write_s = mem_w;
  assign is_read_s  = mem_r & ~mem_w;
  assign in_phase_s = (state_r == ST_LO) || (state_r == ST_HI);

  assign addr_lo_s = ADDR_W'({word_index(alu_res, 32'(BASE_ADDR)), 1'b0});
  assign addr_hi_s = ADDR_W'({word_index(alu_res, 32'(BASE_ADDR)), 1'b1});

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (~in_phase_s),
    .en     (in_phase_s),
    .last   (cnt_last_s),
    .penult (cnt_penult_s)
  );

  // Next-state and stall decode.
  always_comb begin
    state_nxt_s = state_r;
    ready       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_nxt_s = ST_LO;
          ready       = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
          ready       = 1'b1;
        end
      end
      ST_LO: begin
        if (cnt_last_s) begin
          state_nxt_s = ST_HI;
        end else begin
          state_nxt_s = ST_LO;
        end
      end
      ST_HI: begin
        if (cnt_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_HI;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        ready       = 1'b1;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ready       = 1'b0;
      end
    endcase
  end

  // Strobes are registered, so decode the value wanted in the coming cycle:
  // we_n goes high one cycle before each phase ends to close the write cleanly.
  always_comb begin
    we_low_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: we_low_nxt_s = is_write_s;
      ST_LO:   we_low_nxt_s = is_write_s & ~cnt_penult_s;
      ST_HI:   we_low_nxt_s = is_write_s & ~cnt_penult_s & ~cnt_last_s;
      ST_DONE: we_low_nxt_s = 1'b0;
      default: we_low_nxt_s = 1'b0;
    endcase
  end

  assign oe_nxt_s     = is_write_s & ((state_nxt_s == ST_LO) || (state_nxt_s == ST_HI));
  assign load_lo_s    = (state_r == ST_IDLE) & req_s;
  assign load_hi_s    = (state_r == ST_LO) & cnt_last_s;
  assign capture_lo_s = (state_r == ST_LO) & cnt_last_s & is_read_s;
  assign capture_hi_s = (state_r == ST_HI) & cnt_last_s & is_read_s;

  // State register and write strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      sram_we_n  <= ~we_low_nxt_s;
      sram_dq_oe <= oe_nxt_s;
    end
  end

  // Address and write data are loaded at each phase entry and held for the phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr <= {ADDR_W{1'b0}};
      sram_dq_o <= 16'h0000;
    end else if (load_lo_s) begin
      sram_addr <= addr_lo_s;
      sram_dq_o <= is_write_s ? val_rm[15:0] : sram_dq_o;
    end else if (load_hi_s) begin
      sram_addr <= addr_hi_s;
      sram_dq_o <= is_write_s ? val_rm[31:16] : sram_dq_o;
    end else begin
      sram_addr <= sram_addr;
      sram_dq_o <= sram_dq_o;
    end
  end

  // Load data is captured on the last wait cycle of each read phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_data <= 32'h0000_0000;
    end else if (capture_lo_s) begin
      mem_data[15:0] <= sram_dq_i;
    end else if (capture_hi_s) begin
      mem_data[31:16] <= sram_dq_i;
    end else begin
      mem_data <= mem_data;
    end
  end

endmodule

// File: tb/tb_mem_sram_stage.sv
// Self-checking bench for mem_sram_stage: directed and random loads/stores against
// a halfword-level SRAM model and a reference derived from the address arithmetic.
module tb_mem_sram_stage;

  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;
  localparam int          W    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_en, mem_r, mem_w;
  logic [31:0]   alu_res, val_rm;
  logic [3:0]    dest;
  logic          wb_en_out, mem_r_out;
  logic [3:0]    dest_out;
  logic [31:0]   alu_res_out, mem_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_we_n;

  logic          d4_mem_r, d4_mem_w;
  logic          w4_wb_en_out, w4_mem_r_out, w4_ready, w4_oe, w4_we_n;
  logic [3:0]    w4_dest_out;
  logic [31:0]   w4_alu_res_out, w4_mem_data;
  logic [AW-1:0] w4_addr;
  logic [15:0]   w4_dq_o;
  logic [15:0]   w4_dq_i = 16'hA5A5;

  logic [15:0]   sram [0:(1<<AW)-1];
  logic [15:0]   ref_hw [int];
  logic [31:0]   exp_md;
  int            n_vec  = 0;
  int            n_miss = 0;

  always #5 clk = ~clk;

  mem_sram_stage #(.BASE_ADDR(1024), .ADDR_W(18), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .mem_r(mem_r), .mem_w(mem_w),
    .alu_res(alu_res), .val_rm(val_rm), .dest(dest),
    .wb_en_out(wb_en_out), .mem_r_out(mem_r_out), .dest_out(dest_out),
    .alu_res_out(alu_res_out), .mem_data(mem_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n));

  mem_sram_stage #(.BASE_ADDR(1024), .ADDR_W(18), .WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .wb_en(wb_en), .mem_r(d4_mem_r), .mem_w(d4_mem_w),
    .alu_res(alu_res), .val_rm(val_rm), .dest(dest),
    .wb_en_out(w4_wb_en_out), .mem_r_out(w4_mem_r_out), .dest_out(w4_dest_out),
    .alu_res_out(w4_alu_res_out), .mem_data(w4_mem_data), .ready(w4_ready),
    .sram_addr(w4_addr), .sram_dq_o(w4_dq_o), .sram_dq_i(w4_dq_i),
    .sram_dq_oe(w4_oe), .sram_we_n(w4_we_n));

  assign sram_dq_i = sram[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n) sram[sram_addr] <= sram_dq_o;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned hw_index(input logic [31:0] a, input int unsigned hi);
    logic [31:0] off;
    off = a - BASE;
    return (((off / 32'd4) * 32'd2) + hi) % (32'd1 << AW);
  endfunction

  // One complete transaction on the default-parameter DUT, starting at a negedge with
  // the DUT idle; returns at the negedge of the following idle cycle.
  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    int unsigned lo, hi;
    int          low, p;
    bit          done;
    lo = hw_index(a, 0);
    hi = hw_index(a, 1);
    mem_r = r; mem_w = w; alu_res = a; val_rm = d;
    wb_en = 1'($urandom); dest = 4'($urandom);
    low = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      if (k == 0) begin
        check("pass_dest", {dest_out, wb_en_out, mem_r_out}, {dest, wb_en, mem_r});
        check("pass_alu", alu_res_out, a);
      end
      if (ready) begin
        done = 1'b1;
      end else begin
        if (k >= 1) begin
          p = k - 1;
          check("sram_addr", sram_addr, (p < W) ? lo : hi);
          if (w) begin
            check("we_n_wr", sram_we_n, (p % W) == (W - 1));
            check("oe_wr", sram_dq_oe, 1'b1);
            check("dq_o", sram_dq_o, (p < W) ? d[15:0] : d[31:16]);
            check("md_hold_wr", mem_data, exp_md);
          end else begin
            check("we_n_rd", sram_we_n, 1'b1);
            check("oe_rd", sram_dq_oe, 1'b0);
          end
        end
        low++;
        @(negedge clk);
      end
    end
    check("ready_seen", done, 1'b1);
    check("low_cycles", low, 1 + 2 * W);
    if (w) begin
      ref_hw[lo] = d[15:0];
      ref_hw[hi] = d[31:16];
      check("sram_lo", sram[lo], d[15:0]);
      check("sram_hi", sram[hi], d[31:16]);
    end else begin
      exp_md = {ref_hw[hi], ref_hw[lo]};
    end
    check("mem_data", mem_data, exp_md);
    check("done_we_n", sram_we_n, 1'b1);
    check("done_oe", sram_dq_oe, 1'b0);
    @(negedge clk);
    mem_r = 1'b0; mem_w = 1'b0;
  endtask

  initial begin
    int          low4;
    bit          done4;
    logic [31:0] a, d;
    rst = 1'b0; wb_en = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
    alu_res = 32'd0; val_rm = 32'd0; dest = 4'd0;
    d4_mem_r = 1'b0; d4_mem_w = 1'b0;
    exp_md = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_oe", sram_dq_oe, 1'b0);
    check("rst_addr", sram_addr, 0);
    check("rst_dq_o", sram_dq_o, 16'h0);
    check("rst_md", mem_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Idle: pass-throughs follow inputs combinationally, no SRAM activity.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wb_en = 1'($urandom); dest = 4'($urandom); alu_res = $urandom;
      #1;
      check("idle_pass", {wb_en_out, mem_r_out, dest_out, alu_res_out},
            {wb_en, 1'b0, dest, alu_res});
      check("idle_ready", ready, 1'b1);
      check("idle_we_oe", {sram_we_n, sram_dq_oe}, 2'b10);
    end
    @(negedge clk);

    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    check("store_hw0", sram[0], 16'hBEEF);
    check("store_hw1", sram[1], 16'hDEAD);
    access(1'b0, 1'b1, 32'd1036, 32'h12345678);
    access(1'b1, 1'b0, 32'd1036, 32'h0);
    check("load_1036", exp_md, 32'h12345678);
    d = $urandom;
    access(1'b0, 1'b1, 32'd1040, d);
    access(1'b1, 1'b0, 32'd1040, 32'h0);
    access(1'b1, 1'b1, 32'd1044, $urandom);
    access(1'b1, 1'b0, 32'd1044, 32'h0);
    access(1'b0, 1'b1, 32'd1024 + 32'd4 * (32'd1 << 17), 32'hCAFE0F0F);
    check("wrap_hw0", sram[0], 16'h0F0F);
    access(1'b1, 1'b0, 32'd1024, 32'h0);

    for (int s = 0; s < 16; s++) access(1'b0, 1'b1, BASE + 4 * s, $urandom);
    for (int i = 0; i < 30; i++) begin
      a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0:       access(1'b1, 1'b0, a, $urandom);
        1:       access(1'b0, 1'b1, a, $urandom);
        default: access(1'b1, 1'b1, a, $urandom);
      endcase
    end
    access(1'b1, 1'b0, 32'd1036, 32'h0);

    // Reset asserted during the high-half phase of a store.
    mem_w = 1'b1; alu_res = BASE + 4 * 100; val_rm = 32'h55AA33CC;
    repeat (3) @(negedge clk);
    mem_w = 1'b0;
    rst = 1'b0;
    #1;
    exp_md = 32'h0;
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_we_oe", {sram_we_n, sram_dq_oe}, 2'b10);
    check("mid_rst_addr", {sram_addr, sram_dq_o}, 34'h0);
    check("mid_rst_md", mem_data, exp_md);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(1'b1, 1'b0, BASE + 4 * 7, 32'h0);

    // Four wait states per half on the second instance.
    d4_mem_r = 1'b1; alu_res = BASE + 8;
    low4 = 0; done4 = 1'b0;
    for (int k = 0; k < 40 && !done4; k++) begin
      #1;
      if (w4_ready) begin
        done4 = 1'b1;
      end else begin
        check("w4_we_oe", {w4_we_n, w4_oe}, 2'b10);
        low4++;
        @(negedge clk);
      end
    end
    check("w4_ready_seen", done4, 1'b1);
    check("w4_low_cycles", low4, 9);
    check("w4_mem_data", w4_mem_data, 32'hA5A5A5A5);
    check("w4_pass", {w4_wb_en_out, w4_mem_r_out, w4_dest_out, w4_alu_res_out},
          {wb_en, 1'b1, dest, alu_res});
    check("w4_addr_dq", {w4_addr, w4_dq_o}, {18'd5, 16'h0});
    @(negedge clk);
    d4_mem_r = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
